sar_search_4bit: RTL
====================

Name: sar_search_4bit

Overview:
- Initiator side of the 4-bit magnitude comparator interface.
- Searches for an unknown operand A held on the comparator's a-inputs. It drives trial values onto the comparator's b-inputs and consumes ceq/clt/cgt, using successive approximation (binary search).
- Reports the recovered value, a found/verified flag and a step count.
- Sits next to the comparator in the combinational-circuits area, as the first sequential consumer of its outputs.

Parameters:
- W, 4, operand width. Probe/result width. Must match comparator width.
- SW, $clog2(W+2), width of the step counter. Derived; do not override.

Ports:
- clk    in   1      rising-edge clock
- rst_n  in   1      asynchronous active-low reset
- start  in   1      begin a search. Sampled only in IDLE.
- ceq    in   1      comparator: A == probe
- clt    in   1      comparator: A < probe
- cgt    in   1      comparator: A > probe
- probe  out  W      trial value driven to comparator b-inputs. Registered.
- busy   out  1      high in SEARCH and VERIFY
- done   out  1      one-cycle pulse when a search ends (normal or error)
- result out  W      recovered value. Held until the next done.
- found  out  1      result verified equal to A. Valid with done, then held.
- err    out  1      comparator flags were not one-hot during the search. Held.
- steps  out  SW     number of compare cycles used. Held.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - probe, result, steps = 0.
  - busy, done, found, err = 0.
- Comparator is combinational. Flags are sampled on the same edge that probe is presented; no extra latency.
- IDLE:
  - busy=0.
  - On start: probe <= 1<<(W-1), bit index k <= W-1, steps <= 0, clear found/err, go to SEARCH.
- SEARCH (one compare per cycle; steps increments each cycle):
  - Flags not exactly one-hot: err<=1, found<=0, result<=probe, done pulse, go to IDLE.
  - ceq: result<=probe, found<=1, done pulse, go to IDLE. This is early termination.
  - cgt: keep bit k. clt: clear bit k.
  - If k>0: also set bit k-1, k<=k-1, stay in SEARCH.
  - If k==0: go to VERIFY with the adjusted probe.
- VERIFY (one cycle; steps increments):
  - ceq: found<=1. Otherwise found<=0 (A changed mid-search).
  - Flag check as in SEARCH; a non-one-hot pattern sets err.
  - result<=probe, done pulse, go to IDLE.
- Latency from start to done:
  - Minimum 1 compare cycle (A == 1<<(W-1)).
  - Maximum W+1 compare cycles (e.g. A=0).
  - done is asserted in the cycle after the last compare edge.
- start while busy: ignored. No restart, no queueing.
- start held high: a new search begins on the first IDLE cycle after done.
- Reset mid-search: immediate return to IDLE. Outputs zeroed. No done pulse.
- probe returns to 0 in IDLE.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SEARCH, VERIFY);
  - the W default;
  - the step-count width function.
- No sub-module required.
- The bench instantiates comparator_4bit alongside this block as the responder. A is driven on a3..a0, probe connects to b3..b0, and the comparator's ceq/clt/cgt feed back into this block.

Test Plan:
- A=5, start: probes 8,4,6,5 → done with result=5, found=1, steps=4, err=0.
- A=0: probes 8,4,2,1 then VERIFY 0 → result=0, found=1, steps=5.
- A=8: first probe ceq → done two cycles after start, result=8, steps=1. A=15: probes 8,12,14,15 → steps=4.
- Force ceq=clt=1 during SEARCH (comparator bypassed) → err=1, found=0, done pulse, then IDLE.
- Change A from 3 to 12 after the second probe → VERIFY fails, found=0, err=0, done pulse.
- Assert rst_n=0 mid-SEARCH → busy, probe, steps = 0 immediately. No done. A new start works normally.

Source files
------------

// File: rtl/sar_search_4bit_pkg.sv
// Shared types and sizing helpers for the 4-bit successive-approximation searcher.
// Holds the FSM state encoding, the default operand width and the step-counter width rule.
// No logic lives here.
package sar_search_4bit_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2
  } state_t;

  // The step counter must reach W+1 (full search plus the verify compare).
  function automatic int step_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/comparator_4bit.sv
// 4-bit unsigned magnitude comparator: reports A==B, A<B, A>B.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module comparator_4bit (
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  output logic ceq,
  output logic clt,
  output logic cgt
);

  logic [3:0] a_val;
  logic [3:0] b_val;

  assign a_val = {a3, a2, a1, a0};
  assign b_val = {b3, b2, b1, b0};

  // Exactly one flag is high for any input pair.
  always_comb begin
    ceq = (a_val == b_val);
    clt = (a_val <  b_val);
    cgt = (a_val >  b_val);
  end

endmodule

// File: rtl/sar_search_4bit.sv
// Binary-search initiator that recovers the comparator's hidden operand A via trial probes.
// Latency: 1 to W+1 compare cycles from start; done pulses the cycle after the last compare.
// start is ignored while busy; results are held until the next done.
module sar_search_4bit
  import sar_search_4bit_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = step_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ceq,
  input  logic          clt,
  input  logic          cgt,
  output logic [W-1:0]  probe,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          found,
  output logic          err,
  output logic [SW-1:0] steps
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  state_t        state_q,  state_d;
  logic [W-1:0]  probe_q,  probe_d;
  logic [KW-1:0] k_q,      k_d;
  logic [SW-1:0] steps_q,  steps_d;
  logic [W-1:0]  result_q, result_d;
  logic          found_q,  found_d;
  logic          err_q,    err_d;
  logic          done_q,   done_d;

  logic          flags_onehot;
  logic [W-1:0]  probe_adj;

  // Comparator sanity plus the next trial value: resolve bit k, then tentatively set bit k-1.
  always_comb begin
    flags_onehot = ({ceq, clt, cgt} == 3'b100) ||
                   ({ceq, clt, cgt} == 3'b010) ||
                   ({ceq, clt, cgt} == 3'b001);
    probe_adj = probe_q;
    if (clt) begin
      probe_adj[k_q] = 1'b0;
    end
    if (k_q != '0) begin
      probe_adj[k_q - KW'(1)] = 1'b1;
    end
  end

  // Next-state and datapath updates; every search exit returns probe to zero.
  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    k_d      = k_q;
    steps_d  = steps_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        probe_d = '0;
        if (start) begin
          probe_d[W-1] = 1'b1;
          k_d          = KW'(W - 1);
          steps_d      = '0;
          found_d      = 1'b0;
          err_d        = 1'b0;
          state_d      = SEARCH;
        end
      end
      SEARCH: begin
        steps_d = steps_q + SW'(1);
        if (!flags_onehot) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = probe_q;
          done_d   = 1'b1;
          probe_d  = '0;
          state_d  = IDLE;
        end else if (ceq) begin
          result_d = probe_q;
          found_d  = 1'b1;
          done_d   = 1'b1;
          probe_d  = '0;
          state_d  = IDLE;
        end else if (k_q != '0) begin
          probe_d = probe_adj;
          k_d     = k_q - KW'(1);
        end else begin
          probe_d = probe_adj;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        // A mismatch here means A moved during the search.
        steps_d  = steps_q + SW'(1);
        found_d  = flags_onehot && ceq;
        err_d    = !flags_onehot;
        result_d = probe_q;
        done_d   = 1'b1;
        probe_d  = '0;
        state_d  = IDLE;
      end
      default: begin
        probe_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      k_q      <= '0;
      steps_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      k_q      <= k_d;
      steps_q  <= steps_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule
